// File: rtl/rib_pkg.sv
// Shared types and constants for the RIB round-robin crossbar.
// Holds the FSM encoding, the decode-error fill word and default geometry.
package rib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } rib_state_e;

  localparam int RIB_MST_NUM = 3;
  localparam int RIB_SLV_NUM = 2;
  localparam int RIB_SEL_W   = 4;

  localparam logic [31:0] RIB_DEC_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rib_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester
// found after last_grant, wrapping modulo MST_NUM.
module rib_rr_arb
  import rib_pkg::*;
#(
  parameter int MST_NUM = RIB_MST_NUM,
  parameter int LGW     = $clog2(MST_NUM)
) (
  input  logic [MST_NUM-1:0] req,
  input  logic [LGW-1:0]     last_grant,
  output logic [MST_NUM-1:0] grant
);

  // Scan farthest-first so the nearest requester overwrites.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int k = MST_NUM; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % MST_NUM;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_rr_xbar.sv
// RIB crossbar: round-robin masters onto address-decoded slaves,
// one transaction per two cycles (ACCESS then DONE).
module rib_rr_xbar
  import rib_pkg::*;
#(
  parameter int MST_NUM = RIB_MST_NUM,
  parameter int SLV_NUM = RIB_SLV_NUM,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_W   = RIB_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [MST_NUM-1:0]    rib_req_mst,
  input  logic [MST_NUM-1:0]    rib_wr_en_mst,
  input  logic [MST_NUM*AW-1:0] rib_addr_mst,
  input  logic [MST_NUM*DW-1:0] rib_wdata_mst,
  output logic [MST_NUM*DW-1:0] rib_rdata_mst,
  output logic [MST_NUM-1:0]    rib_ack_mst,
  output logic [MST_NUM-1:0]    rib_hold_mst,
  output logic [SLV_NUM-1:0]    rib_req_slv,
  output logic [SLV_NUM-1:0]    rib_wr_en_slv,
  output logic [SLV_NUM*AW-1:0] rib_addr_slv,
  output logic [SLV_NUM*DW-1:0] rib_wdata_slv,
  input  logic [SLV_NUM*DW-1:0] rib_rdata_slv,
  output logic                  rib_err
);

  localparam int LGW = $clog2(MST_NUM);
  localparam logic [DW-1:0] ERR_DATA =
    DW'(RIB_DEC_ERR_DATA);

  rib_state_e         st_q, st_d;
  logic [LGW-1:0]     last_q, win_q, win_d;
  logic [MST_NUM-1:0] gnt;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q, slv_rd;
  logic [SEL_W-1:0]   sel;
  logic               wr_q, grant, dec_err;

  assign sel     = addr_q[AW-1 -: SEL_W];
  assign dec_err = int'(sel) >= SLV_NUM;
  assign grant   = (|rib_req_mst) &&
                   (st_q != ST_ACCESS);

  assign rib_hold_mst = rib_req_mst & ~rib_ack_mst;

  rib_rr_arb #(
    .MST_NUM (MST_NUM),
    .LGW     (LGW)
  ) u_arb (
    .req        (rib_req_mst),
    .last_grant (last_q),
    .grant      (gnt)
  );

  always_comb begin
    win_d = '0;
    for (int i = 0; i < MST_NUM; i++)
      if (gnt[i]) win_d = LGW'(i);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE, ST_DONE:
        st_d = grant ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:
        st_d = ST_DONE;
      default:
        st_d = ST_IDLE;
    endcase
  end

  // Winner request is latched so a later drop cannot abort it.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      last_q  <= LGW'(MST_NUM - 1);
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (grant) begin
      last_q  <= win_d;
      win_q   <= win_d;
      addr_q  <= rib_addr_mst[int'(win_d)*AW +: AW];
      wdata_q <= rib_wdata_mst[int'(win_d)*DW +: DW];
      wr_q    <= rib_wr_en_mst[win_d];
    end
  end

  always_comb begin
    slv_rd = '0;
    for (int s = 0; s < SLV_NUM; s++)
      if (int'(sel) == s)
        slv_rd = rib_rdata_slv[s*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)
      rib_rdata_mst <= '0;
    else if (st_q == ST_DONE)
      rib_rdata_mst[int'(win_q)*DW +: DW] <=
        dec_err ? ERR_DATA : slv_rd;
  end

  always_comb begin
    rib_ack_mst   = '0;
    rib_err       = 1'b0;
    rib_req_slv   = '0;
    rib_wr_en_slv = '0;
    rib_addr_slv  = '0;
    rib_wdata_slv = '0;
    unique case (1'b1)
      st_q == ST_DONE: begin
        rib_ack_mst[win_q] = 1'b1;
        rib_err            = dec_err;
      end
      st_q == ST_ACCESS && !dec_err: begin
        for (int s = 0; s < SLV_NUM; s++)
          if (int'(sel) == s) begin
            rib_req_slv[s]              = 1'b1;
            rib_wr_en_slv[s]            = wr_q;
            rib_addr_slv[s*AW +: AW]    = addr_q;
            rib_wdata_slv[s*DW +: DW]   = wdata_q;
          end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rib_rr_xbar.md
RIB_RR_XBAR -- requirements
Module: rib_rr_xbar

Interface
REQ-001 SHALL have parameter MST_NUM, default 3, number of bus masters (2..8).
REQ-002 SHALL have parameter SLV_NUM, default 2, number of slaves (1..16).
REQ-003 SHALL have parameter AW, default 32, address width.
REQ-004 SHALL have parameter DW, default 32, data width.
REQ-005 SHALL have parameter SEL_W, default 4, slave-select field width, taken from addr[AW-1 -: SEL_W].
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_b  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rib_req_mst  in  MST_NUM  per-master request.
REQ-009 SHALL have port rib_wr_en_mst  in  MST_NUM  per-master write enable (1 = write).
REQ-010 SHALL have port rib_addr_mst  in  MST_NUM*AW  packed addresses, master i at [i*AW +: AW].
REQ-011 SHALL have port rib_wdata_mst  in  MST_NUM*DW  packed write data.
REQ-012 SHALL have port rib_rdata_mst  out  MST_NUM*DW  packed, registered read data.
REQ-013 SHALL have port rib_ack_mst  out  MST_NUM  one-cycle completion pulse per master.
REQ-014 SHALL have port rib_hold_mst  out  MST_NUM  per-master stall, combinational.
REQ-015 SHALL have port rib_req_slv / rib_wr_en_slv  out  SLV_NUM  per-slave strobe and write enable.
REQ-016 SHALL have port rib_addr_slv / rib_wdata_slv  out  SLV_NUM*AW / SLV_NUM*DW  packed slave address and write data.
REQ-017 SHALL have port rib_rdata_slv  in  SLV_NUM*DW  slave read data, valid one cycle after the slave strobe.
REQ-018 SHALL have port rib_err  out  1  decode-error pulse.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS and DONE; IDLE with no request SHALL stay in IDLE.
REQ-020 In IDLE or DONE with any rib_req_mst bit set, the FSM SHALL register a round-robin winner and go to ACCESS; otherwise it SHALL go to IDLE.
REQ-021 Round-robin: the search SHALL start at last_grant+1 modulo MST_NUM; last_grant SHALL update on every grant.
REQ-022 ACCESS SHALL last exactly one cycle.
REQ-023 In ACCESS the winner's addr, wdata and wr_en SHALL be registered at grant; rib_req_slv[sel] SHALL be 1 for that cycle only; all other slave strobes SHALL be 0.
REQ-024 Unselected slave addr and wdata buses SHALL be driven 0.
REQ-025 In DONE, rib_rdata_mst[winner] SHALL load rib_rdata_slv[sel].
REQ-026 In DONE, rib_ack_mst[winner] SHALL be 1 for one cycle.
REQ-027 Each rib_rdata_mst field SHALL hold its value until that master's next ack.
REQ-028 Latency: request seen in IDLE at cycle N SHALL give ACCESS at N+1 and ack at N+2.
REQ-029 Back-to-back throughput SHALL be one transaction per 2 cycles.
REQ-030 rib_hold_mst[i] SHALL equal rib_req_mst[i] AND NOT (state==DONE AND winner==i).
REQ-031 sel >= SLV_NUM SHALL produce no slave strobe; DONE SHALL then load RIB_DEC_ERR_DATA (32'hDEAD_BEEF, truncated/zero-extended to DW) and pulse rib_err with the ack.
REQ-032 A granted transaction SHALL complete even if the master drops its request after grant.
REQ-033 A write SHALL also capture the slave rdata (don't-care content); the ack SHALL still pulse.
REQ-034 Simultaneous requests SHALL yield exactly one grant per arbitration; losers SHALL remain held.

Reset
REQ-035 Reset SHALL force FSM to IDLE, last_grant to MST_NUM-1 (so master 0 wins first), all rdata fields to 0, and all acks, slave strobes, slave buses and rib_err to 0.
REQ-036 Reset asserted mid-ACCESS SHALL abort the transaction with no ack, and the first post-reset arbitration SHALL follow REQ-035.

Structure
REQ-037 Shared package rib_pkg SHALL hold the FSM state encoding, RIB_DEC_ERR_DATA, and the default MST_NUM/SLV_NUM/SEL_W.
REQ-038 Sub-module rib_rr_arb SHALL be used: parametrised MST_NUM round-robin arbiter taking req vector and last_grant, returning a one-hot grant.

Verification
REQ-039 After reset, req_mst=3'b111, all reads of 0x0000_0010 -> acks on masters 0,1,2 at cycles 2,4,6; hold drops for each master only on its ack cycle.
REQ-040 Master 2 writes 0x1000_0004 with 0xCAFE_F00D, then reads back -> slave 1 strobe with wr_en=1, then read ack with rdata_mst[2]=0xCAFE_F00D.
REQ-041 Master 1 reads 0x3000_0000 with SLV_NUM=2 -> no slave strobe; ack with rdata=0xDEAD_BEEF and rib_err=1 for one cycle.
REQ-042 Master 0 drops req in the ACCESS cycle -> ack still pulses; no second grant to master 0.
REQ-043 rst_b asserted during ACCESS -> no ack, all outputs 0; after release with req=3'b011, master 0 is granted first.
REQ-044 Master 1 requests continuously with master 0 idle -> grants every 2 cycles; once master 0 asserts req, grants alternate 0,1,0,1.
